// File: rtl/instr_sequencer.sv
// Program sequencer: replays a program held in on-chip RAM onto the processor's
// mode/F/address/data inputs, one instruction per clock.
module instr_sequencer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] instr_count,
  output logic          mode,
  output logic [2:0]    F,
  output logic [4:0]    read_addr1,
  output logic [4:0]    read_addr2,
  output logic [4:0]    dest_addr,
  output logic [4:0]    store_addr,
  output logic [31:0]   store_data
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e        state_q;
  logic [31:0]   ram_q [DEPTH];
  logic [31:0]   ir_q;
  logic          ir_valid_q;
  logic          ir_last_q;
  logic [AW-1:0] pc_q;
  logic          advance;
  logic          prog_ok;
  logic          unused_ir;

  assign advance   = (state_q == StRun) && !hold;
  assign prog_ok   = prog_we && !rst && (state_q != StRun);
  assign unused_ir = ir_q[26];

  // Synchronous-read program RAM; the fetched word is frozen while held.
  always_ff @(posedge clk) begin
    if (prog_ok) ram_q[prog_addr] <= prog_data;
    if (advance) ir_q <= ram_q[pc_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      instr_count <= '0;
      pc_q        <= '0;
      ir_valid_q  <= 1'b0;
      ir_last_q   <= 1'b0;
      mode        <= 1'b1;
      F           <= '0;
      read_addr1  <= '0;
      read_addr2  <= '0;
      dest_addr   <= '0;
      store_addr  <= '0;
      store_data  <= '0;
    end else begin
      // Idle bus (harmless store of 0 to r0) unless an instruction issues below.
      mode       <= 1'b1;
      F          <= '0;
      read_addr1 <= '0;
      read_addr2 <= '0;
      dest_addr  <= '0;
      store_addr <= '0;
      store_data <= '0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StRun;
            busy        <= 1'b1;
            done        <= 1'b0;
            instr_count <= '0;
            pc_q        <= '0;
            ir_valid_q  <= 1'b0;
            ir_last_q   <= 1'b0;
          end else if (prog_ok) begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        StRun: begin
          if (!hold) begin
            pc_q       <= pc_q + 1'b1;
            ir_valid_q <= 1'b1;
            ir_last_q  <= (pc_q == LastAddr);
            if (ir_valid_q) begin
              case (ir_q[31:30])
                2'b01: begin
                  store_addr <= ir_q[25:21];
                  store_data <= {16'b0, ir_q[15:0]};
                  if (instr_count != '1) instr_count <= instr_count + 1'b1;
                end
                2'b10: begin
                  mode       <= 1'b0;
                  F          <= ir_q[29:27];
                  dest_addr  <= ir_q[25:21];
                  read_addr1 <= ir_q[20:16];
                  read_addr2 <= ir_q[15:11];
                  if (instr_count != '1) instr_count <= instr_count + 1'b1;
                end
                default: ;
              endcase
              // HALT or the final RAM word ends the run; pc never wraps into a reissue.
              if (ir_q[31:30] == 2'b11 || ir_last_q) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed programs plus random programs/hold,
// checked every edge against a progress-counter reference model.
module tb_instr_sequencer;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 16;
  localparam logic [55:0] IDLE_BUS = {1'b1, 55'd0};

  logic          clk = 1'b0;
  logic          rst, prog_we, start, hold;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          busy, done, mode;
  logic [CW-1:0] instr_count;
  logic [2:0]    f_out;
  logic [4:0]    ra1, ra2, dest, saddr;
  logic [31:0]   sdata;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 run, 2 done; m_p counts un-held edges since start.
  logic [31:0] m_ram [DEPTH];
  int          m_state = 0;
  int          m_p     = 0;
  int          m_count = 0;
  logic [55:0] exp_bus;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .hold(hold), .busy(busy), .done(done),
    .instr_count(instr_count), .mode(mode), .F(f_out), .read_addr1(ra1),
    .read_addr2(ra2), .dest_addr(dest), .store_addr(saddr), .store_data(sdata)
  );

  always #5 clk = ~clk;

  // Bus packing: {mode, F, read_addr1, read_addr2, dest_addr, store_addr, store_data}
  function automatic logic [55:0] decode(input logic [31:0] w);
    case (w[31:30])
      2'b01:   return {1'b1, 3'd0, 5'd0, 5'd0, 5'd0, w[25:21], 16'd0, w[15:0]};
      2'b10:   return {1'b0, w[29:27], w[20:16], w[15:11], w[25:21], 5'd0, 32'd0};
      default: return IDLE_BUS;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] w;
    exp_bus = IDLE_BUS;
    if (rst) begin
      m_state = 0;
      m_count = 0;
    end else if (m_state == 1) begin
      if (!hold) begin
        if (m_p > 0) begin
          w = m_ram[m_p-1];
          exp_bus = decode(w);
          if ((w[31:30] == 2'b01 || w[31:30] == 2'b10) && m_count < 65535) m_count++;
          if (w[31:30] == 2'b11 || m_p == DEPTH) m_state = 2;
        end
        m_p++;
      end
    end else begin
      if (prog_we) m_ram[prog_addr] = prog_data;
      if (start) begin
        m_state = 1;
        m_p     = 0;
        m_count = 0;
      end else if (prog_we) begin
        m_state = 0;
      end
    end
    @(posedge clk);
    #1;
    check("bus", {8'd0, mode, f_out, ra1, ra2, dest, saddr, sdata}, {8'd0, exp_bus});
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("count", instr_count, m_count);
  endtask

  task automatic load(input int a, input logic [31:0] w);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = w;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ticks until DUT done rises; returns edges taken after the start edge.
  task automatic run_to_done(input int max, input int hold_pct, output int n);
    n = 0;
    while (!done && n < max) begin
      hold = ($urandom_range(99) < hold_pct);
      tick();
      n++;
    end
    hold = 1'b0;
    check("run_timeout", n < max, 1);
  endtask

  task automatic load_basic();
    load(0, {2'b01, 4'd0, 5'd1, 5'd0, 16'd5});
    load(1, {2'b01, 4'd0, 5'd11, 5'd0, 16'd15});
    load(2, {2'b10, 3'b100, 1'b0, 5'd21, 5'd1, 5'd11, 11'd0});
    load(3, {2'b11, 30'd0});
  endtask

  initial begin
    int n;
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
    rst = 1'b1; prog_we = 1'b0; start = 1'b0; hold = 1'b0;
    prog_addr = '0; prog_data = '0;

    // Reset
    tick();
    tick();
    rst = 1'b0;

    // Basic program: issues on edges 2..4, done on edge 5
    load_basic();
    pulse_start();
    run_to_done(50, 0, n);
    check("t2_done_edge", n, 5);
    check("t2_count", instr_count, 3);
    tick();

    // Hold for 3 cycles after the first issue
    pulse_start();
    tick();
    tick();
    hold = 1'b1;
    tick(); tick(); tick();
    hold = 1'b0;
    run_to_done(50, 0, n);
    check("t3_done_edge", n + 5, 8);
    check("t3_count", instr_count, 3);

    // NOP prefix then HALT
    for (int i = 0; i < 3; i++) load(i, {2'b00, 30'($urandom)});
    load(3, {2'b11, 30'($urandom)});
    pulse_start();
    run_to_done(50, 0, n);
    check("t6_done_edge", n, 5);
    check("t6_count", instr_count, 0);

    // 64 ALU words, no HALT: must stop after address 63
    for (int i = 0; i < DEPTH; i++) load(i, {2'b10, 30'($urandom)});
    pulse_start();
    run_to_done(200, 0, n);
    check("t4_done_edge", n, 65);
    check("t4_count", instr_count, 64);
    tick();
    tick();
    check("t4_no_wrap", done, 1);

    // start/prog_we during RUN ignored; reset mid-run; rerun
    load_basic();
    pulse_start();
    tick();
    start = 1'b1; prog_we = 1'b1; prog_addr = AW'(1); prog_data = {2'b11, 30'd0};
    tick();
    start = 1'b0; prog_we = 1'b0;
    run_to_done(50, 0, n);
    check("t5_done_edge", n + 2, 5);
    check("t5_count", instr_count, 3);
    pulse_start();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_idle", {busy, done, mode}, 3'b001);
    tick();
    pulse_start();
    run_to_done(50, 0, n);
    check("t5_rerun_count", instr_count, 3);

    // Random programs with random hold
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) begin
        w = $urandom;
        if (w[31:30] == 2'b11 && $urandom_range(3) != 0) w[31] = 1'b0;
        load(i, w);
      end
      pulse_start();
      run_to_done(400, 30, n);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
